row_request_encoder: RTL

ROW_REQUEST_ENCODER -- requirements
Module: row_request_encoder

---
 rtl/row_request_encoder_if.sv | 36 +++
 rtl/row_request_encoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/row_request_encoder_if.sv
// -----------------------------------------------------------------------------
// row_request_encoder_if
// Request/grant bundle between a row-request producer/consumer and the
// row_request_encoder.
//   i_request [7:0] : per-row request strobes (bit n = row n), pulses or levels
//   i_ready         : consumer accepts o_address this cycle
//   o_address [2:0] : encoded row index of the current grant
//   o_valid         : o_address holds a granted row awaiting acceptance
//   o_pending [7:0] : registered pending-request vector
// Modports:
//   master : drives requests/ready, observes grant and pending vector
//   slave  : the encoder side
// -----------------------------------------------------------------------------
interface row_request_encoder_if;
    logic [7:0] i_request;
    logic       i_ready;
    logic [2:0] o_address;
    logic       o_valid;
    logic [7:0] o_pending;

    modport master (
        output i_request,
        output i_ready,
        input  o_address,
        input  o_valid,
        input  o_pending
    );

    modport slave (
        input  i_request,
        input  i_ready,
        output o_address,
        output o_valid,
        output o_pending
    );
endinterface

// File: rtl/row_request_encoder.sv
// -----------------------------------------------------------------------------
// row_request_encoder
// Captures per-row request strobes into a sticky pending vector and offers one
// pending row at a time as a binary-encoded address with a valid/ready
// handshake. Back-to-back grants are possible, one per cycle.
//
// Ports:
//   i_clk   : rising-edge clock for all state
//   i_rst_n : asynchronous active-low reset
//   bus     : row_request_encoder_if.slave (i_request, i_ready, o_address,
//             o_valid, o_pending)
//
// Configuration macro:
//   ROW_REQUEST_ENCODER_ROUND_ROBIN_EN
//     undefined : fixed priority, lowest row index wins
//     defined   : round-robin, search starts one past the last accepted row
// -----------------------------------------------------------------------------
module row_request_encoder (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    row_request_encoder_if.slave        bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_r;
    logic [7:0] pending_r;
    logic [2:0] address_r;
    logic       valid_r;

`ifdef ROW_REQUEST_ENCODER_ROUND_ROBIN_EN
    logic [2:0] rr_ptr_r;
`endif

    logic       accept_s;
    logic [7:0] clear_s;
    logic [7:0] remain_s;
    logic [2:0] start_s;
    logic [3:0] pick_s;

    // One-hot decode of a row index.
    function automatic logic [7:0] row_onehot(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    // First set bit of vec scanning upward from start with wrap 7->0.
    // Returns {found, row}.
    function automatic logic [3:0] pick_row(input logic [7:0] vec,
                                            input logic [2:0] start);
        logic       found_v;
        logic [2:0] row_v;
        logic [2:0] idx_v;
        found_v = 1'b0;
        row_v   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx_v = 3'(int'(start) + i);
            if (!found_v && vec[idx_v]) begin
                found_v = 1'b1;
                row_v   = idx_v;
            end
        end
        return {found_v, row_v};
    endfunction

    // Handshake decode and next-row selection. Selection only looks at the
    // registered pending vector minus the row being accepted, so requests
    // arriving this cycle become eligible one edge later. In IDLE clear_s is
    // zero, so remain_s is simply the pending vector.
    always_comb begin
        accept_s = valid_r & bus.i_ready;
        if (accept_s) begin
            clear_s = row_onehot(address_r);
        end else begin
            clear_s = 8'h00;
        end
        remain_s = pending_r & ~clear_s;
`ifdef ROW_REQUEST_ENCODER_ROUND_ROBIN_EN
        if (accept_s) begin
            start_s = address_r + 3'd1;
        end else begin
            start_s = rr_ptr_r + 3'd1;
        end
`else
        start_s = 3'd0;
`endif
        pick_s = pick_row(remain_s, start_s);
    end

    // Pending capture (set wins over clear) and the IDLE/OFFER grant FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= IDLE;
            pending_r <= 8'h00;
            address_r <= 3'd0;
            valid_r   <= 1'b0;
`ifdef ROW_REQUEST_ENCODER_ROUND_ROBIN_EN
            rr_ptr_r  <= 3'd7;
`endif
        end else begin
            pending_r <= remain_s | bus.i_request;
            case (state_r)
                IDLE: begin
                    if (pick_s[3]) begin
                        state_r   <= OFFER;
                        valid_r   <= 1'b1;
                        address_r <= pick_s[2:0];
                    end else begin
                        state_r   <= IDLE;
                        valid_r   <= 1'b0;
                    end
                end
                OFFER: begin
                    if (accept_s) begin
`ifdef ROW_REQUEST_ENCODER_ROUND_ROBIN_EN
                        rr_ptr_r <= address_r;
`endif
                        if (pick_s[3]) begin
                            state_r   <= OFFER;
                            valid_r   <= 1'b1;
                            address_r <= pick_s[2:0];
                        end else begin
                            state_r   <= IDLE;
                            valid_r   <= 1'b0;
                        end
                    end else begin
                        state_r   <= OFFER;
                        valid_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_address = address_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_pending = pending_r;

endmodule
